// File: rtl/store_narrow_if.sv
// Store request / byte-wide memory write bundle for store_narrow.
// The slave modport is the narrowing unit; master is the store stage plus memory.
interface store_narrow_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        done;
    logic        align_err;
    logic        trunc_ok;

    modport slave (
        input  req_valid, req_size, req_addr, req_data, mem_ready,
        output req_ready, mem_we, mem_addr, mem_wdata, done, align_err, trunc_ok
    );

    modport master (
        output req_valid, req_size, req_addr, req_data, mem_ready,
        input  req_ready, mem_we, mem_addr, mem_wdata, done, align_err, trunc_ok
    );
endinterface

// File: rtl/store_narrow.sv
// Narrows a 32-bit store (sb/sh/sw) into big-endian byte writes on an 8-bit port
// and reports alignment errors and whether the truncation preserved the value.
module store_narrow (
    input  logic          clk,
    input  logic          rst_n,
    store_narrow_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] shift_reg, shift_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        err_reg, err_next;
    logic        trunc_reg, trunc_next;

    logic        req_err;
    logic        req_trunc;
    logic [1:0]  req_last;
    logic [31:0] req_shifted;

    // Kept field is left-justified so the current byte is always shift_reg[31:24].
    always_comb begin
        req_err     = 1'b0;
        req_trunc   = 1'b1;
        req_last    = 2'd0;
        req_shifted = bus.req_data;
        case (bus.req_size)
            2'b00: begin
                req_last    = 2'd0;
                req_shifted = {bus.req_data[7:0], 24'h0};
                req_trunc   = (&bus.req_data[31:7]) | ~(|bus.req_data[31:7]);
            end
            2'b01: begin
                req_last    = 2'd1;
                req_shifted = {bus.req_data[15:0], 16'h0};
                req_err     = bus.req_addr[0];
                req_trunc   = (&bus.req_data[31:15]) | ~(|bus.req_data[31:15]);
            end
            2'b10: begin
                req_last    = 2'd3;
                req_shifted = bus.req_data;
                req_err     = |bus.req_addr[1:0];
            end
            default: begin
                req_err = 1'b1;
            end
        endcase
        if (req_err) begin
            req_trunc = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        trunc_next = trunc_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_next  = bus.req_addr;
                    shift_next = req_shifted;
                    cnt_next   = req_last;
                    err_next   = req_err;
                    trunc_next = req_trunc;
                    state_next = req_err ? FINISH : WRITE;
                end
            end
            WRITE: begin
                if (bus.mem_ready) begin
                    if (cnt_reg == 2'd0) begin
                        state_next = FINISH;
                    end else begin
                        cnt_next   = cnt_reg - 2'd1;
                        addr_next  = addr_reg + 32'd1;
                        shift_next = {shift_reg[23:0], 8'h00};
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= 32'h0;
            shift_reg <= 32'h0;
            cnt_reg   <= 2'd0;
            err_reg   <= 1'b0;
            trunc_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            trunc_reg <= trunc_next;
        end
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.mem_we    = (state_reg == WRITE);
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = shift_reg[31:24];
    assign bus.done      = (state_reg == FINISH);
    assign bus.align_err = (state_reg == FINISH) & err_reg;
    assign bus.trunc_ok  = (state_reg == FINISH) & trunc_reg;
endmodule

// File: tb/tb_store_narrow.sv
// Randomized self-checking bench for store_narrow against a byte-list reference model.
module tb_store_narrow;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    store_narrow_if bus ();

    store_narrow dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Caller is positioned at a negedge with the unit idle; returns at a negedge, idle again.
    task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] data, input int stall0, input bit rnd_stall);
        int          n;
        bit          err;
        bit          trunc;
        logic [31:0] sx8, sx16, sh, exp_addr;
        int          st;

        err  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00);
        n    = err ? 0 : (1 << size);
        sx8  = {{24{data[7]}}, data[7:0]};
        sx16 = {{16{data[15]}}, data[15:0]};
        trunc = !err && ((size == 2'b10) || (size == 2'b00 && sx8 == data) ||
                         (size == 2'b01 && sx16 == data));
        $display("store size=%0d addr=%h data=%h -> bytes=%0d err=%0d trunc=%0d",
                 size, addr, data, n, err, trunc);

        check("req_ready", {31'h0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_size  = 2'($urandom);
        bus.req_addr  = $urandom;
        bus.req_data  = $urandom;

        for (int i = 0; i < n; i++) begin
            st = (i == 0) ? stall0 : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            sh = data >> (8 * (n - 1 - i));
            exp_addr = addr + 32'(i);
            for (int s = 0; s <= st; s++) begin
                check("mem_we", {31'h0, bus.mem_we}, 32'd1);
                check("mem_addr", bus.mem_addr, exp_addr);
                check("mem_wdata", {24'h0, bus.mem_wdata}, {24'h0, sh[7:0]});
                check("done_early", {31'h0, bus.done}, 32'd0);
                bus.mem_ready = (s == st);
                @(negedge clk);
            end
        end
        bus.mem_ready = 1'b0;
        check("mem_we_fin", {31'h0, bus.mem_we}, 32'd0);
        check("done", {31'h0, bus.done}, 32'd1);
        check("align_err", {31'h0, bus.align_err}, {31'h0, err});
        check("trunc_ok", {31'h0, bus.trunc_ok}, {31'h0, trunc});
        @(negedge clk);
        check("done_pulse", {31'h0, bus.done}, 32'd0);
    endtask

    initial begin
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_data;
        int          mode;

        bus.req_valid = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h0;
        bus.req_data  = 32'h0;
        bus.mem_ready = 1'b0;

        // Reset
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
        check("rst_mem_we", {31'h0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", {24'h0, bus.mem_wdata}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'd0);
        check("rst_align_err", {31'h0, bus.align_err}, 32'd0);
        check("rst_trunc_ok", {31'h0, bus.trunc_ok}, 32'd0);

        // Directed cases
        do_store(2'b10, 32'h100, 32'h12345678, 0, 1'b0);
        do_store(2'b01, 32'h22,  32'hFFFF8001, 3, 1'b0);
        do_store(2'b00, 32'h7,   32'h00000180, 0, 1'b0);
        do_store(2'b00, 32'h7,   32'hFFFFFF80, 0, 1'b0);
        do_store(2'b10, 32'h102, 32'hDEADBEEF, 0, 1'b0);
        do_store(2'b01, 32'h3,   32'h00001234, 0, 1'b0);
        do_store(2'b11, 32'h40,  32'h00000001, 0, 1'b0);
        do_store(2'b01, 32'hFFFFFFFE, 32'h00007FFF, 1, 1'b0);

        // Reset in the middle of a word store
        $display("store size=2 addr=00000200 data=a1b2c3d4 -> reset after second byte");
        bus.req_valid = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h200;
        bus.req_data  = 32'hA1B2C3D4;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid_b0", {24'h0, bus.mem_wdata}, 32'hA1);
        @(negedge clk);
        check("mid_b1", {24'h0, bus.mem_wdata}, 32'hB2);
        @(negedge clk);
        check("mid_b2_addr", bus.mem_addr, 32'h202);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_we", {31'h0, bus.mem_we}, 32'd0);
        check("mid_rst_done", {31'h0, bus.done}, 32'd0);
        check("mid_rst_ready", {31'h0, bus.req_ready}, 32'd1);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("mid_after_we", {31'h0, bus.mem_we}, 32'd0);
        check("mid_after_done", {31'h0, bus.done}, 32'd0);
        do_store(2'b00, 32'h55, 32'h0000007F, 0, 1'b0);

        // Randomized stores, mostly legal, with random stalls
        for (int t = 0; t < 60; t++) begin
            r_size = 2'($urandom_range(0, 3));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0 && r_size != 2'b11)
                r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
            mode = $urandom_range(0, 2);
            r_data = $urandom;
            if (mode == 1) r_data = {{24{r_data[7]}}, r_data[7:0]};
            if (mode == 2) r_data = {{16{r_data[15]}}, r_data[15:0]};
            do_store(r_size, r_addr, r_data, $urandom_range(0, 2), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
